// File: rtl/regfile_p.sv
// ============================================================================
// Module   : regfile_p
// Purpose  : Parametrised register file, 2 combinational read ports, 1 write
//            port, optional write-through bypass and hardwired-zero entry 0.
//            A sequential clear engine zeroes the array after reset and on
//            request; writes are ignored while it runs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_p #(
  parameter int W       = 8,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] wa3,
  input  logic [W-1:0]  wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic          clr,
  output logic [W-1:0]  rd1,
  output logic [W-1:0]  rd2,
  output logic          busy
);

  localparam int D = 2**AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   cnt_q;
  logic [W-1:0]    regs_q [D];

  logic            wr_eff;
  logic            clr_wr;
  logic            zero_wa;

  // A write to entry 0 is discarded when entry 0 is hardwired to zero
  assign zero_wa = (ZERO_R0 != 0) && (wa3 == '0);
  assign wr_eff  = we && (state_q == ST_IDLE) && !clr && !zero_wa;
  // A clr seen while clearing restarts the sweep and clears nothing that edge
  assign clr_wr  = (state_q == ST_CLEAR) && !clr;
  assign busy    = (state_q == ST_CLEAR);

  // Clear-engine FSM: sweep cnt over every entry, then idle until clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr) begin
            cnt_q <= '0;
          end else if (cnt_q == AW'(D-1)) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Storage update: clear sweep has priority; no reset on the array itself
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      regs_q[cnt_q] <= '0;
    end else if (wr_eff) begin
      regs_q[wa3] <= wd3;
    end
  end

  // Read port 1: clearing -> 0, hardwired zero -> 0, bypass, else array
  always_comb begin
    rd1 = regs_q[ra1];
    if (state_q == ST_CLEAR) begin
      rd1 = '0;
    end else if ((ZERO_R0 != 0) && (ra1 == '0)) begin
      rd1 = '0;
    end else if ((BYPASS != 0) && wr_eff && (wa3 == ra1)) begin
      rd1 = wd3;
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rd2 = regs_q[ra2];
    if (state_q == ST_CLEAR) begin
      rd2 = '0;
    end else if ((ZERO_R0 != 0) && (ra2 == '0)) begin
      rd2 = '0;
    end else if ((BYPASS != 0) && wr_eff && (wa3 == ra2)) begin
      rd2 = wd3;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_p.sv
// ============================================================================
// Module   : tb_regfile_p
// Purpose  : Self-checking bench for regfile_p. Two instances share stimulus:
//            u_a (BYPASS=1, ZERO_R0=0) and u_b (BYPASS=0, ZERO_R0=1), each
//            checked against a behavioural model of the register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_p;

  logic       clk = 1'b0;
  logic       rst_n, we, clr;
  logic [3:0] wa3, ra1, ra2;
  logic [7:0] wd3;
  logic [7:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic       busy_a, busy_b;

  always #5 clk = ~clk;

  regfile_p #(.W(8), .AW(4), .ZERO_R0(0), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .we(we), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .clr(clr), .rd1(rd1_a), .rd2(rd2_a), .busy(busy_a)
  );

  regfile_p #(.W(8), .AW(4), .ZERO_R0(1), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .we(we), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2), .clr(clr), .rd1(rd1_b), .rd2(rd2_b), .busy(busy_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: contents per instance plus number of clear edges still owed
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  int         left;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input bit z, input bit b,
                                        input logic [3:0] ra, input logic [7:0] stored);
    bit eff;
    eff = we && (left == 0) && !clr && !(z && wa3 == 4'd0);
    if (left > 0)                    return 8'h00;
    if (z && ra == 4'd0)             return 8'h00;
    if (b && eff && wa3 == ra)       return wd3;
    return stored;
  endfunction

  task automatic check_all();
    chk("busy_a", 32'(busy_a), 32'(left > 0));
    chk("busy_b", 32'(busy_b), 32'(left > 0));
    chk("rd1_a", 32'(rd1_a), 32'(exp_rd(1'b0, 1'b1, ra1, mem_a[ra1])));
    chk("rd2_a", 32'(rd2_a), 32'(exp_rd(1'b0, 1'b1, ra2, mem_a[ra2])));
    chk("rd1_b", 32'(rd1_b), 32'(exp_rd(1'b1, 1'b0, ra1, mem_b[ra1])));
    chk("rd2_b", 32'(rd2_b), 32'(exp_rd(1'b1, 1'b0, ra2, mem_b[ra2])));
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      left = 16;
    end else if (left > 0) begin
      if (clr) begin
        left = 16;
      end else begin
        mem_a[16-left] = 8'h00;
        mem_b[16-left] = 8'h00;
        left--;
      end
    end else if (clr) begin
      left = 16;
    end else if (we) begin
      mem_a[wa3] = wd3;
      if (wa3 != 4'd0) mem_b[wa3] = wd3;
    end
  endtask

  // One cycle: check mid-cycle, advance model on the edge, settle
  task automatic cyc();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Count edges until busy falls, bounded; optionally fire random writes
  task automatic clear_len(input string tag, input bit wr_noise);
    int e;
    e = 0;
    while (busy_a && e < 40) begin
      if (wr_noise) begin
        we  = 1'b1;
        wa3 = 4'($urandom);
        wd3 = 8'($urandom);
        ra1 = 4'($urandom);
      end
      cyc();
      e++;
    end
    chk(tag, 32'(e), 32'd16);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    rst_n = 1'b0; we = 1'b0; clr = 1'b0;
    wa3 = '0; wd3 = '0; ra1 = 4'd5; ra2 = 4'd9;
    left = 16;
    #1;
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_rd1",  32'(rd1_a),  32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    clear_len("reset_clear_len", 1'b0);

    // All entries zero after the first clear
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      ra2 = 4'(15 - i);
      #1;
      chk("post_clear_rd1", 32'(rd1_a), 32'd0);
      cyc();
    end

    // Plain writes, read back next cycle
    we = 1'b1; wa3 = 4'd3;  wd3 = 8'hA5; ra1 = 4'd0; ra2 = 4'd0; cyc();
    we = 1'b1; wa3 = 4'd15; wd3 = 8'h3C; cyc();
    we = 1'b0; ra1 = 4'd3; ra2 = 4'd15; #1;
    chk("wr_rd1_A5", 32'(rd1_a), 32'hA5);
    chk("wr_rd2_3C", 32'(rd2_a), 32'h3C);
    cyc();

    // Bypass visible same cycle on u_a only
    we = 1'b1; wa3 = 4'd7; wd3 = 8'h5A; ra1 = 4'd7; #1;
    chk("bypass_a", 32'(rd1_a), 32'h5A);
    chk("nobypass_b", 32'(rd1_b), 32'h00);
    cyc();
    we = 1'b0; #1;
    chk("after_edge_b", 32'(rd1_b), 32'h5A);
    cyc();

    // Hardwired zero on u_b
    we = 1'b1; wa3 = 4'd0; wd3 = 8'hFF; cyc();
    wa3 = 4'd1; cyc();
    we = 1'b0; ra1 = 4'd0; ra2 = 4'd1; #1;
    chk("r0_zero_b", 32'(rd1_b), 32'h00);
    chk("r0_write_a", 32'(rd1_a), 32'hFF);
    chk("r1_write_b", 32'(rd2_b), 32'hFF);
    cyc();

    // Write colliding with clr is dropped; writes during clear ignored
    we = 1'b1; wa3 = 4'd2; wd3 = 8'h11; cyc();
    clr = 1'b1; wa3 = 4'd4; wd3 = 8'h22; ra1 = 4'd4; #1;
    chk("clr_no_bypass", 32'(rd1_a), 32'h00);
    cyc();
    clr = 1'b0;
    chk("clr_busy", 32'(busy_a), 32'd1);
    clear_len("clr_clear_len", 1'b1);
    we = 1'b0; ra1 = 4'd2; ra2 = 4'd4; #1;
    chk("clr_addr2", 32'(rd1_a), 32'h00);
    chk("clr_addr4", 32'(rd2_a), 32'h00);
    cyc();

    // Reset part-way through a clear (after 9 entries) restarts the sweep
    clr = 1'b1; cyc();
    clr = 1'b0;
    repeat (9) cyc();
    rst_n = 1'b0; left = 16; #1;
    chk("midclr_rst_busy", 32'(busy_a), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;
    clear_len("midclr_clear_len", 1'b0);

    // Randomised traffic with occasional clear requests
    for (int n = 0; n < 600; n++) begin
      we  = 1'($urandom);
      wa3 = 4'($urandom);
      wd3 = 8'($urandom);
      ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 4'($urandom);
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 4'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      cyc();
    end
    clr = 1'b0; we = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
